// File: rtl/trace_pkg.sv
// Shared types and constants for the retire trace buffer slice.
package trace_pkg;

    // Field widths of a stored trace record (the buffer's default configuration).
    localparam int unsigned TRACE_XLEN = 32;
    localparam int unsigned TRACE_TS_W = 32;
    localparam int unsigned TRACE_CH_W = 2;   // enough for up to 4 lanes
    localparam int unsigned DROP_W     = 16;

    // Privilege mode encodings as seen on in_priv.
    typedef enum logic [2:0] {
        PRIV_U = 3'd0,
        PRIV_S = 3'd1,
        PRIV_M = 3'd3
    } priv_e;

    // One buffered retire record.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           inst;
        logic [4:0]            wrdst;
        logic [TRACE_XLEN-1:0] wrdata;
        logic                  wrenx;
        logic                  wrenf;
        logic                  excpt;
        logic [2:0]            priv;
        logic [TRACE_CH_W-1:0] ch;
        logic [TRACE_TS_W-1:0] timestamp;
        logic                  gap;
    } trace_rec_t;

    // Saturating add used by the drop counter.
    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0] cur,
        input logic [DROP_W-1:0] inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/trace_lane_compactor.sv
// Counts qualifying lanes and gives each lane its exclusive prefix count,
// i.e. its slot offset from the write pointer.
module trace_lane_compactor #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned NW     = $clog2(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0]         i_q,
    output logic [NW-1:0]             o_n,
    output logic [NUM_CH-1:0][NW-1:0] o_off
);

    // Running prefix count across lanes in ascending order.
    always_comb begin
        logic [NW-1:0] acc;
        acc   = '0;
        o_off = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            o_off[i] = acc;
            acc      = acc + NW'(i_q[i]);
        end
        o_n = acc;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Multi-lane retire trace capture: qualifies lanes, compacts them into a
// timestamped FIFO in program order, drains one record per cycle.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_enable,
    input  logic                   cfg_excpt_only,
    input  logic                   clr_overflow,
    input  logic [NUM_CH-1:0]      in_valid,
    input  logic [NUM_CH*XLEN-1:0] in_pc,
    input  logic [NUM_CH*32-1:0]   in_inst,
    input  logic [NUM_CH*5-1:0]    in_wrdst,
    input  logic [NUM_CH*XLEN-1:0] in_wrdata,
    input  logic [NUM_CH-1:0]      in_wrenx,
    input  logic [NUM_CH-1:0]      in_wrenf,
    input  logic [NUM_CH-1:0]      in_excpt,
    input  logic [NUM_CH*3-1:0]    in_priv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [31:0]            out_inst,
    output logic [4:0]             out_wrdst,
    output logic [XLEN-1:0]        out_wrdata,
    output logic                   out_wrenx,
    output logic                   out_wrenf,
    output logic                   out_excpt,
    output logic [2:0]             out_priv,
    output logic [CH_W-1:0]        out_ch,
    output logic [TS_W-1:0]        out_timestamp,
    output logic                   out_gap,
    output logic [CW-1:0]          count,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned NW = $clog2(NUM_CH + 1);

    // State
    logic [TS_W-1:0]   r_ts;
    logic [AW-1:0]     r_rptr;
    logic [AW-1:0]     r_wptr;
    logic [CW-1:0]     r_count;
    logic [DROP_W-1:0] r_drop;
    logic              r_ovf;
    logic              r_gap_pending;
    trace_rec_t        r_mem [DEPTH];

    // Combinational
    logic [NUM_CH-1:0]         w_q;
    logic [NW-1:0]             w_n;
    logic [NUM_CH-1:0][NW-1:0] w_off;
    logic [AW-1:0]             w_slot [NUM_CH];
    trace_rec_t                w_rec  [NUM_CH];
    logic [CW-1:0]             w_free;
    logic                      w_any;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_pop;
    logic                      w_out_vld;
    trace_rec_t                w_head;

    // Lane qualification.
    always_comb begin
        w_q = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_q[i] = cfg_enable & in_valid[i] & (~cfg_excpt_only | in_excpt[i]);
        end
    end

    trace_lane_compactor #(
        .NUM_CH (NUM_CH),
        .NW     (NW)
    ) u_compactor (
        .i_q   (w_q),
        .o_n   (w_n),
        .o_off (w_off)
    );

    // Group admission: uses start-of-cycle occupancy, so a same-cycle pop frees nothing.
    always_comb begin
        w_free    = CW'(DEPTH) - r_count;
        w_any     = (w_n != '0);
        w_accept  = w_any && (CW'(w_n) <= w_free);
        w_drop    = w_any && !w_accept;
        w_out_vld = (r_count != '0);
        w_pop     = w_out_vld & out_ready;
    end

    // Per-lane record assembly and target slot.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_slot[i]          = r_wptr + AW'(w_off[i]);
            w_rec[i].pc        = TRACE_XLEN'(in_pc[i*XLEN +: XLEN]);
            w_rec[i].inst      = in_inst[i*32 +: 32];
            w_rec[i].wrdst     = in_wrdst[i*5 +: 5];
            w_rec[i].wrdata    = TRACE_XLEN'(in_wrdata[i*XLEN +: XLEN]);
            w_rec[i].wrenx     = in_wrenx[i];
            w_rec[i].wrenf     = in_wrenf[i];
            w_rec[i].excpt     = in_excpt[i];
            w_rec[i].priv      = in_priv[i*3 +: 3];
            w_rec[i].ch        = TRACE_CH_W'(i);
            w_rec[i].timestamp = TRACE_TS_W'(r_ts);
            // Only the oldest record of an accepted group carries the gap mark.
            w_rec[i].gap       = r_gap_pending & (w_off[i] == '0);
        end
    end

    // Record storage; contents are not reset.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_accept && w_q[i]) begin
                r_mem[w_slot[i]] <= w_rec[i];
            end
        end
    end

    // Free-running capture timestamp.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + AW'(w_n);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (w_accept ? CW'(w_n) : '0) - CW'(w_pop);
        end
    end

    // Drop accounting: saturating counter, sticky flag (set beats clear), gap marker.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop        <= '0;
            r_ovf         <= 1'b0;
            r_gap_pending <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop        <= sat_add_drop(r_drop, DROP_W'(w_n));
                r_gap_pending <= 1'b1;
            end else if (w_accept) begin
                r_gap_pending <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_overflow) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head record, gated to zero while the FIFO is empty.
    always_comb begin
        w_head        = r_mem[r_rptr];
        out_valid     = w_out_vld;
        out_pc        = w_out_vld ? XLEN'(w_head.pc)        : '0;
        out_inst      = w_out_vld ? w_head.inst             : '0;
        out_wrdst     = w_out_vld ? w_head.wrdst            : '0;
        out_wrdata    = w_out_vld ? XLEN'(w_head.wrdata)    : '0;
        out_wrenx     = w_out_vld & w_head.wrenx;
        out_wrenf     = w_out_vld & w_head.wrenf;
        out_excpt     = w_out_vld & w_head.excpt;
        out_priv      = w_out_vld ? w_head.priv             : '0;
        out_ch        = w_out_vld ? CH_W'(w_head.ch)        : '0;
        out_timestamp = w_out_vld ? TS_W'(w_head.timestamp) : '0;
        out_gap       = w_out_vld & w_head.gap;
        count         = r_count;
        drop_count    = r_drop;
        overflow      = r_ovf;
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer (NUM_CH=2, DEPTH=4).
module tb_retire_trace_buffer;

    localparam int NC = 2;
    localparam int XL = 32;
    localparam int DP = 4;
    localparam int TW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_enable, cfg_excpt_only, clr_overflow;
    logic [NC-1:0] in_valid, in_wrenx, in_wrenf, in_excpt;
    logic [NC*XL-1:0] in_pc, in_wrdata;
    logic [NC*32-1:0] in_inst;
    logic [NC*5-1:0]  in_wrdst;
    logic [NC*3-1:0]  in_priv;
    logic          out_valid, out_ready;
    logic [XL-1:0] out_pc, out_wrdata;
    logic [31:0]   out_inst;
    logic [4:0]    out_wrdst;
    logic          out_wrenx, out_wrenf, out_excpt, out_gap;
    logic [2:0]    out_priv;
    logic [0:0]    out_ch;
    logic [TW-1:0] out_timestamp;
    logic [2:0]    count;
    logic [15:0]   drop_count;
    logic          overflow;

    retire_trace_buffer #(.NUM_CH(NC), .XLEN(XL), .DEPTH(DP), .TS_W(TW)) dut (
        .clock(clock), .reset(reset),
        .cfg_enable(cfg_enable), .cfg_excpt_only(cfg_excpt_only), .clr_overflow(clr_overflow),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_wrdst(in_wrdst),
        .in_wrdata(in_wrdata), .in_wrenx(in_wrenx), .in_wrenf(in_wrenf),
        .in_excpt(in_excpt), .in_priv(in_priv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_wrdst(out_wrdst), .out_wrdata(out_wrdata),
        .out_wrenx(out_wrenx), .out_wrenf(out_wrenf), .out_excpt(out_excpt), .out_priv(out_priv),
        .out_ch(out_ch), .out_timestamp(out_timestamp), .out_gap(out_gap),
        .count(count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  wrdst;
        logic [31:0] wrdata;
        logic        wrenx, wrenf, excpt;
        logic [2:0]  priv;
        int          ch;
        logic [31:0] ts;
        logic        gap;
    } rec_t;

    // Reference model state
    rec_t        exp_q[$];
    int          m_occ = 0;
    int          m_drop = 0;
    bit          m_ovf = 0, m_gap = 0;
    logic [31:0] m_ts = '0;
    // Expected register view for the current cycle
    bit          exp_valid = 0, exp_ovf = 0;
    int          exp_cnt = 0, exp_drop = 0;
    bit          in_rst = 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle of the reference model, evaluated from the inputs just driven.
    task automatic model_step();
        rec_t grp[$];
        rec_t r;
        int   pop;
        exp_valid = (m_occ != 0);
        exp_cnt   = m_occ;
        exp_drop  = m_drop;
        exp_ovf   = m_ovf;
        for (int l = 0; l < NC; l++) begin
            if (cfg_enable && in_valid[l] && (!cfg_excpt_only || in_excpt[l])) begin
                r.pc     = in_pc[l*XL +: XL];
                r.inst   = in_inst[l*32 +: 32];
                r.wrdst  = in_wrdst[l*5 +: 5];
                r.wrdata = in_wrdata[l*XL +: XL];
                r.wrenx  = in_wrenx[l];
                r.wrenf  = in_wrenf[l];
                r.excpt  = in_excpt[l];
                r.priv   = in_priv[l*3 +: 3];
                r.ch     = l;
                r.ts     = m_ts;
                r.gap    = 1'b0;
                grp.push_back(r);
            end
        end
        pop = (m_occ > 0 && out_ready) ? 1 : 0;
        if (grp.size() > 0) begin
            if (grp.size() <= DP - m_occ) begin
                for (int k = 0; k < grp.size(); k++) begin
                    r = grp[k];
                    r.gap = (k == 0) ? m_gap : 1'b0;
                    exp_q.push_back(r);
                end
                m_occ += grp.size();
                m_gap = 0;
            end else begin
                m_drop = (m_drop + grp.size() > 65535) ? 65535 : m_drop + grp.size();
                m_ovf  = 1;
                m_gap  = 1;
            end
        end else if (clr_overflow) begin
            m_ovf = 0;
        end
        if (grp.size() > 0 && grp.size() <= DP - exp_cnt && clr_overflow) m_ovf = 0;
        m_occ -= pop;
        m_ts  += 1;
    endtask

    task automatic drive(input bit en, input bit eo, input bit clr, input bit rdy,
                         input logic [1:0] v, input logic [1:0] ex,
                         input logic [31:0] pc0, input logic [31:0] pc1);
        cfg_enable     = en;
        cfg_excpt_only = eo;
        clr_overflow   = clr;
        out_ready      = rdy;
        in_valid       = v;
        in_excpt       = ex;
        in_pc          = {pc1, pc0};
        for (int l = 0; l < NC; l++) begin
            in_inst[l*32 +: 32]   = $urandom;
            in_wrdst[l*5 +: 5]    = 5'($urandom_range(0, 31));
            in_wrdata[l*XL +: XL] = $urandom;
            in_wrenx[l]           = 1'($urandom_range(0, 1));
            in_wrenf[l]           = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       in_priv[l*3 +: 3] = 3'd0;
                1:       in_priv[l*3 +: 3] = 3'd1;
                default: in_priv[l*3 +: 3] = 3'd3;
            endcase
        end
        model_step();
    endtask

    task automatic cyc(input bit en, input bit eo, input bit clr, input bit rdy,
                       input logic [1:0] v, input logic [1:0] ex,
                       input logic [31:0] pc0, input logic [31:0] pc1);
        @(negedge clock);
        drive(en, eo, clr, rdy, v, ex, pc0, pc1);
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, rdy, 2'b00, 2'b00, '0, '0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
    task automatic reset_pulse();
        @(negedge clock);
        in_rst         = 1;
        cfg_enable     = 0;
        cfg_excpt_only = 0;
        clr_overflow   = 0;
        out_ready      = 0;
        in_valid       = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_head_zero", {out_pc, out_timestamp}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        m_occ = 0; m_drop = 0; m_ovf = 0; m_gap = 0; m_ts = '0;
        in_rst = 0;
        drive(1, 0, 0, 0, 2'b00, 2'b00, '0, '0);
    endtask

    // Monitor: compares status every cycle and the head record against the scoreboard.
    initial begin
        rec_t e;
        forever begin
            @(negedge clock);
            #4;
            if (!in_rst) begin
                chk("out_valid", 64'(out_valid), 64'(exp_valid));
                chk("count", 64'(count), 64'(exp_cnt));
                chk("drop_count", 64'(drop_count), 64'(exp_drop));
                chk("overflow", 64'(overflow), 64'(exp_ovf));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("head_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q[0];
                        chk("head_pc", 64'(out_pc), 64'(e.pc));
                        chk("head_inst", 64'(out_inst), 64'(e.inst));
                        chk("head_wrdst", 64'(out_wrdst), 64'(e.wrdst));
                        chk("head_wrdata", 64'(out_wrdata), 64'(e.wrdata));
                        chk("head_flags", {out_wrenx, out_wrenf, out_excpt, out_priv, out_ch, out_gap},
                            {e.wrenx, e.wrenf, e.excpt, e.priv, 1'(e.ch), e.gap});
                        chk("head_timestamp", 64'(out_timestamp), 64'(e.ts));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_head_zero",
                        {out_pc, out_timestamp},
                        64'd0);
                    chk("idle_flags_zero", {out_wrenx, out_wrenf, out_excpt, out_priv, out_ch, out_gap,
                                            out_wrdst}, 64'd0);
                end
            end
        end
    end

    initial begin
        cfg_enable = 0; cfg_excpt_only = 0; clr_overflow = 0; out_ready = 0;
        in_valid = '0; in_pc = '0; in_inst = '0; in_wrdst = '0; in_wrdata = '0;
        in_wrenx = '0; in_wrenf = '0; in_excpt = '0; in_priv = '0;

        reset_pulse();

        // Single lane-0 record captured at timestamp 5, then held and drained.
        idle(0, 4);
        cyc(1, 0, 0, 0, 2'b01, 2'b00, 32'h8000_0000, 32'h0);
        idle(0, 2);
        idle(1, 2);

        // Two lanes in one cycle drain in lane order.
        cyc(1, 0, 0, 1, 2'b11, 2'b00, 32'h100, 32'h104);
        idle(1, 3);

        // Fill, overflow, no space from a same-cycle pop, then gap-marked record.
        cyc(1, 0, 0, 0, 2'b11, 2'b00, 32'h10, 32'h14);
        cyc(1, 0, 0, 0, 2'b11, 2'b00, 32'h18, 32'h1c);
        cyc(1, 0, 0, 0, 2'b11, 2'b00, 32'h20, 32'h24);
        cyc(1, 0, 0, 1, 2'b01, 2'b00, 32'h28, 32'h0);
        cyc(1, 0, 0, 0, 2'b01, 2'b00, 32'h300, 32'h0);
        idle(1, 6);

        // Exception-only filter.
        cyc(1, 1, 0, 0, 2'b11, 2'b10, 32'h1f0, 32'h200);
        idle(0, 1);
        idle(1, 3);

        // Drop with clr_overflow in the same cycle, then clear alone.
        cyc(1, 0, 0, 0, 2'b11, 2'b00, 32'h40, 32'h44);
        cyc(1, 0, 0, 0, 2'b11, 2'b00, 32'h48, 32'h4c);
        cyc(1, 0, 1, 0, 2'b11, 2'b00, 32'h50, 32'h54);
        cyc(1, 0, 1, 0, 2'b00, 2'b00, 32'h0, 32'h0);
        idle(0, 1);
        idle(1, 6);

        // Three records buffered, then asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 2'b01, 2'b00, 32'h600 + 32'(i), 32'h0);
        reset_pulse();
        cyc(1, 0, 0, 0, 2'b10, 2'b00, 32'h0, 32'h700);
        idle(1, 3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        // Disabled capture drops nothing while draining continues.
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 2'b11, 2'b11, $urandom, $urandom);

        // Drive the drop counter into saturation and hold it there.
        for (int i = 0; i < 40000 && m_drop < 65535; i++)
            cyc(1, 0, 0, 0, 2'b11, 2'b00, $urandom, $urandom);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 2'b11, 2'b00, $urandom, $urandom);
        @(negedge clock);
        #4 chk("drop_saturated", 64'(drop_count), 64'hFFFF);
        idle(1, 8);

        @(negedge clock);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
